// File: rtl/lsu_input_bank.sv
// lsu_input_bank: synchronised, debounced input bank with sticky edge flags,
// maskable level interrupt and a 16-byte little-endian wrapping register window.
module lsu_input_bank #(
   parameter int IN_W      = 32,
   parameter int DB_CYCLES = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [IN_W-1:0] in_i,
   input  logic [3:0]      addr_i,
   input  logic            we_i,
   input  logic [3:0]      be_i,
   input  logic [31:0]     wdata_i,
   output logic [31:0]     rdata_o,
   output logic            irq_o
);
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [IN_W-1:0] s1_q, s2_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d, en_q, en_d;
   logic [CW-1:0]   cnt_q [IN_W];
   logic [CW-1:0]   cnt_d [IN_W];
   logic [31:0]     lane_m, clr;
   logic [127:0]    view;
   logic [3:0]      k;

   always_comb begin
      lane_m = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
      clr    = we_i ? (wdata_i & lane_m) : '0;
      db_d   = db_q;
      for (int i = 0; i < IN_W; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == db_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
            db_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // the set term is OR-ed last so a new edge beats a same-cycle clear
      rise_d = (rise_q & ~((addr_i[3:2] == 2'd1) ? clr[IN_W-1:0] : '0)) | (db_d & ~db_q);
      fall_d = (fall_q & ~((addr_i[3:2] == 2'd2) ? clr[IN_W-1:0] : '0)) | (~db_d & db_q);
      en_d   = (we_i && addr_i[3:2] == 2'd3)
             ? ((en_q & ~lane_m[IN_W-1:0]) | (wdata_i[IN_W-1:0] & lane_m[IN_W-1:0])) : en_q;
   end

   always_comb begin
      view    = {32'(en_q), 32'(fall_q), 32'(rise_q), 32'(db_q)};
      rdata_o = '0;
      k       = '0;
      for (int j = 0; j < 4; j++) begin
         k = addr_i + 4'(j);
         rdata_o[8*j +: 8] = view[{k, 3'b000} +: 8];
      end
   end

   assign irq_o = |((rise_q | fall_q) & en_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= '0;
         s2_q   <= '0;
         db_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
         en_q   <= '0;
         cnt_q  <= '{default: '0};
      end else begin
         s1_q   <= in_i;
         s2_q   <= s1_q;
         db_q   <= db_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         en_q   <= en_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_lsu_input_bank.sv
// tb_lsu_input_bank: directed vectors for the 32-channel bank plus an 8-channel instance.
module tb_lsu_input_bank;
   logic        clk = 0, rst_n = 1;
   logic [31:0] in_i = '0;
   logic [7:0]  in8 = '0;
   logic [3:0]  addr = '0, be = '0;
   logic        we = 0;
   logic [31:0] wdata = '0, rdata, rdata8;
   logic        irq, irq8;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   lsu_input_bank #(.IN_W(32), .DB_CYCLES(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_i(in_i), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq));

   lsu_input_bank #(.IN_W(8), .DB_CYCLES(4)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .in_i(in8), .addr_i(addr), .we_i(we),
      .be_i(be), .wdata_i(wdata), .rdata_o(rdata8), .irq_o(irq8));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic rd8(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata8, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; we = 1;
      tick(1);
      we = 0; be = '0;
   endtask

   initial begin
      // 1: reset and idle
      in_i = 32'hFFFF_FFFF;
      #3 rst_n = 0;
      #1;
      rd("rst_data", 4'h0, 32'h0);
      rd("rst_rise", 4'h4, 32'h0);
      rd("rst_fall", 4'h8, 32'h0);
      rd("rst_en",   4'hC, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      @(negedge clk) rst_n = 1;
      tick(5);
      rd("lat_before", 4'h0, 32'h0);
      tick(1);
      rd("lat_data", 4'h0, 32'hFFFF_FFFF);
      rd("lat_rise", 4'h4, 32'hFFFF_FFFF);
      in_i = '0;
      tick(8);
      rd("fall_all", 4'h8, 32'hFFFF_FFFF);
      wr(4'h4, 32'hFFFF_FFFF, 4'hF);
      wr(4'h8, 32'hFFFF_FFFF, 4'hF);
      rd("clr_rise", 4'h4, 32'h0);
      rd("clr_fall", 4'h8, 32'h0);

      // 2: debounce filter
      in_i = 32'h8; tick(3); in_i = '0; tick(3);
      rd("glitch_data", 4'h0, 32'h0);
      tick(5);
      rd("glitch_data2", 4'h0, 32'h0);
      rd("glitch_rise", 4'h4, 32'h0);
      in_i = 32'h8; tick(4); in_i = '0; tick(2);
      rd("pulse_data", 4'h0, 32'h8);
      rd("pulse_rise", 4'h4, 32'h8);
      tick(6);
      wr(4'h4, 32'hFFFF_FFFF, 4'hF);
      wr(4'h8, 32'hFFFF_FFFF, 4'hF);

      // 3: edge flags, W1C, irq
      wr(4'hC, 32'h10, 4'hF);
      in_i = 32'h10; tick(6);
      in_i = '0; tick(8);
      rd("e_rise", 4'h4, 32'h10);
      rd("e_fall", 4'h8, 32'h10);
      check("e_irq", 32'(irq), 32'h1);
      wr(4'h4, 32'h10, 4'b0001);
      rd("w1c_rise", 4'h4, 32'h0);
      check("w1c_irq_hold", 32'(irq), 32'h1);
      wr(4'h8, 32'h10, 4'b0000);
      rd("be0_fall", 4'h8, 32'h10);
      addr = 4'h8; wdata = 32'h10; be = 4'b0001; we = 1;
      #1;
      check("prewrite_fall", rdata, 32'h10);
      tick(1);
      we = 0; be = '0;
      rd("w1c_fall", 4'h8, 32'h0);
      check("w1c_irq_low", 32'(irq), 32'h0);

      // 4: set/clear collision
      in_i = 32'h1; tick(5);
      addr = 4'h4; wdata = 32'h1; be = 4'b0001; we = 1;
      tick(1);
      we = 0; be = '0;
      rd("coll_data", 4'h0, 32'h1);
      rd("coll_rise", 4'h4, 32'h1);
      wr(4'h4, 32'h1, 4'b0001);
      rd("coll_clr", 4'h4, 32'h0);
      in_i = '0; tick(8);
      wr(4'h8, 32'hFFFF_FFFF, 4'hF);

      // 5: unaligned wrapping reads
      in_i = 32'h4433_2211; tick(6);
      wr(4'h4, 32'hFFFF_FFFF, 4'hF);
      wr(4'hC, 32'hDDCC_BBAA, 4'hF);
      rd("wrap_0", 4'h0, 32'h4433_2211);
      rd("wrap_1", 4'h1, 32'h0044_3322);
      rd("wrap_E", 4'hE, 32'h2211_DDCC);
      rd("wrap_D", 4'hD, 32'h11DD_CCBB);
      wr(4'hC, 32'h0, 4'b0010);
      rd("lane_en", 4'hC, 32'hDDCC_00AA);
      wr(4'h0, 32'h0, 4'hF);
      rd("data_ro", 4'h0, 32'h4433_2211);

      // 6: narrow instance
      in8 = 8'hA5;
      wr(4'hC, 32'hFFFF_FFFF, 4'hF);
      tick(6);
      rd8("n_data", 4'h0, 32'h0000_00A5);
      rd8("n_en",   4'hC, 32'h0000_00FF);
      rd8("n_rise", 4'h4, 32'h0000_00A5);
      check("n_irq", 32'(irq8), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lsu_input_bank.md
Name: lsu_input_bank

Overview:
- Parametrised memory-mapped input peripheral for the LSU I/O region; successor to the plain switch-sampling bank.
- Synchronises and debounces up to 32 raw switch/button inputs.
- Records sticky rising/falling edges and raises a maskable interrupt.
- Exposes a 16-byte register window with little-endian, byte-granular, wrapping 32-bit reads.

Parameters:
- IN_W, 32, number of input channels (1..32); register bits at and above IN_W read 0 and ignore writes.
- DB_CYCLES, 4, consecutive cycles the synchronised input must differ from the debounced value before it is accepted (>=1).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_i  input  IN_W  raw asynchronous switch/button levels.
- addr_i  input  4  byte address into the register window.
- we_i  input  1  write strobe, sampled on rising clk_i.
- be_i  input  4  byte enables for writes.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, combinational from addr_i.
- irq_o  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low. On reset, all registers, synchronisers and counters clear to 0, so rdata_o = 32'h0 at addr 0 and irq_o = 0. Reset mid-debounce discards the count.
- Register map (word offsets):
  - 0x0 DATA: debounced levels, read-only.
  - 0x4 RISE: sticky rising-edge flags, write-1-to-clear.
  - 0x8 FALL: sticky falling-edge flags, write-1-to-clear.
  - 0xC IRQ_EN: per-channel mask, read/write.
- Synchroniser: two flops per channel (s1, s2). No other logic touches in_i.
- Debounce, per channel:
  - Counter cnt, width $clog2(DB_CYCLES+1).
  - If s2 == db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DB_CYCLES synchronised cycles never reaches db.
- Latency: in_i stable before edge 1 makes db change at edge 2+DB_CYCLES.
- Edge flags: on the same edge db goes 0->1, RISE[i] <= 1; on 1->0, FALL[i] <= 1.
- Write-1-to-clear: a write with we_i=1 to 0x4/0x8 clears bit i where wdata_i[i]=1 and the byte lane is enabled in be_i. If a set and a clear hit the same bit in the same cycle, the set wins.
- Writes:
  - Word-granular; addr_i[1:0] is ignored for writes.
  - IRQ_EN updates per enabled byte lane.
  - Writes to DATA have no effect.
  - be_i = 0 is a no-op.
- Reads:
  - Byte view B[0..15] of the four registers, little-endian.
  - rdata_o = {B[addr+3], B[addr+2], B[addr+1], B[addr]}, addresses mod 16. For example, addr 0xE returns {B1, B0, B15, B14}.
  - Reads have no side effects.
- irq_o = |((RISE | FALL) & IRQ_EN), driven from register outputs only.
- Write/read same cycle: rdata_o shows pre-write contents; new values are visible the cycle after the edge.

Test Plan:
1. Reset and idle: assert rst_ni=0 mid-cycle with in_i=32'hFFFF_FFFF, then release. Required: all four words read 0 and irq_o=0. DATA reads 32'hFFFF_FFFF after exactly 2+DB_CYCLES edges; RISE = 32'hFFFF_FFFF on that same edge.
2. Debounce filter (DB_CYCLES=4): pulse in_i[3] high for 3 synchronised cycles, then low. Required: DATA[3] stays 0 and RISE[3]=0. A 4-cycle pulse must set DATA[3]=1 and RISE[3]=1.
3. Edge flags, W1C and irq: with IRQ_EN=32'h0000_0010, drive a rise then fall on in_i[4]. Required: RISE=FALL=32'h10 and irq_o=1. Write 0x4 with 32'h10 and be_i=4'b0001: RISE=0, irq_o stays 1. Write 0x8 with 32'h10 and be_i=4'b0000: FALL unchanged. Write 0x8 with 32'h10 and be_i=4'b0001: FALL=0, then irq_o=0.
4. Set/clear collision: issue a W1C to RISE[0] on the exact edge where db[0] rises. Required: RISE[0]=1 afterwards.
5. Unaligned wrapping read: set DATA=32'h4433_2211 and IRQ_EN=32'hDDCC_BBAA. Required: addr 0x1 reads 32'h0044_3322 (RISE=0); addr 0xE reads 32'h2211_DDCC; addr 0xD reads 32'h11DD_CCBB.
6. IN_W=8: drive in_i=8'hA5 and write IRQ_EN=32'hFFFF_FFFF. Required: DATA=32'h0000_00A5 and IRQ_EN reads 32'h0000_00FF.
